uart_tx_feeder: RTL and testbench

Byte-buffering front end placed directly upstream of `uart_top`. It accepts bytes from a host write port into a circular FIFO, then drains them one at a time into the transmitter's `i_top_start_bit` / `i_top_tx_data` inputs. It paces each byte using the transmitter's busy status, after that status has been synchronised into `i_clk`. The host can write bursts without watching the transmitter, which runs on the slower baud clock.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync2.sv | 41 ++++
 rtl/uart_tx_feeder.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART slice (TX feeder, RX consumer).
//   tx_feed_state_t : drain FSM states of uart_tx_feeder
//   UART_DATA_W     : byte width expected by uart_top
//   ptr_inc         : modulo-2^N pointer increment helper
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } tx_feed_state_t;

    localparam int UART_DATA_W = 8;

    // Pointers are exactly $clog2(DEPTH) bits wide with DEPTH a power of two,
    // so a plain increment wraps modulo DEPTH.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr, input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return (ptr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Generic two-flop level synchroniser, one independent chain per bit.
// Both stages clear to 0 on reset. Shared by the TX feeder (busy) and the
// RX-side consumer.
// Ports:
//   clk  : destination clock
//   srst : synchronous active-high reset
//   d    : asynchronous input level(s)
//   q    : synchronised level(s), two clk cycles of latency
// ---------------------------------------------------------------------------
module uart_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
// Byte FIFO in front of uart_top. The host writes bursts into a circular
// buffer; a small FSM hands bytes one at a time to the transmitter, pacing
// on the transmitter's busy flag after it is synchronised into i_clk.
// Ports:
//   i_clk, i_rst  : system clock, synchronous active-high reset
//   i_wr_en       : host write strobe
//   i_wr_data     : host byte
//   o_full        : FIFO holds DEPTH bytes (registered)
//   o_empty       : FIFO holds 0 bytes (registered)
//   o_count       : occupancy
//   o_overflow    : one-cycle pulse, the cycle after a dropped write
//   i_tx_busy     : transmitter busy, asynchronous to i_clk
//   o_start_bit   : level-held start request to the transmitter
//   o_tx_data     : byte presented to the transmitter, changes only on pop
// ---------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    input  logic                       i_tx_busy,
    output logic                       o_start_bit,
    output logic [DATA_W-1:0]          o_tx_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is deliberately not reset; occupancy alone defines validity.
    logic [DATA_W-1:0] fifo_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              overflow_reg;
    logic [DATA_W-1:0] tx_data_reg;

    tx_feed_state_t    state_reg, state_next;

    logic              busy_s;
    logic              pop;
    logic              wr_accept;
    logic              start_bit;

    uart_sync2 #(
        .WIDTH (1)
    ) u_busy_sync (
        .clk  (i_clk),
        .srst (i_rst),
        .d    (i_tx_busy),
        .q    (busy_s)
    );

    // -----------------------------------------------------------------------
    // Drain FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Drain FSM: next state and outputs. The pop decision uses only
    // registered state, so the write path never sees a combinational loop.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        start_bit  = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty_reg && !busy_s) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                // Held until the transmitter acknowledges via busy, so a
                // slow baud clock cannot miss the request.
                start_bit = 1'b1;
                if (busy_s) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!busy_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A full FIFO still accepts a write in the cycle a pop frees the head slot.
    assign wr_accept = i_wr_en && (!full_reg || pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_accept) begin
            wr_ptr_next = PTR_W'(ptr_inc(32'(wr_ptr_reg), PTR_W));
        end
        if (pop) begin
            rd_ptr_next = PTR_W'(ptr_inc(32'(rd_ptr_reg), PTR_W));
        end
        case ({wr_accept, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO bookkeeping; flags are registered from count_next.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            tx_data_reg  <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            full_reg     <= (count_next == CNT_W'(DEPTH));
            empty_reg    <= (count_next == '0);
            overflow_reg <= i_wr_en && !wr_accept;
            if (pop) begin
                // When full with a simultaneous write, wr_ptr == rd_ptr;
                // the non-blocking read returns the old head as intended.
                tx_data_reg <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            fifo_mem[wr_ptr_reg] <= i_wr_data;
        end
    end

    assign o_full      = full_reg;
    assign o_empty     = empty_reg;
    assign o_count     = count_reg;
    assign o_overflow  = overflow_reg;
    assign o_start_bit = start_bit;
    assign o_tx_data   = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              clk;
    logic              i_rst;
    logic              i_wr_en;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_full;
    logic              o_empty;
    logic [4:0]        o_count;
    logic              o_overflow;
    logic              tx_busy;
    logic              o_start_bit;
    logic [DATA_W-1:0] o_tx_data;

    // Busy source: either driven directly by the stimulus or by a simple
    // transmitter model that answers each start request.
    logic auto_mode;
    logic man_busy;
    logic model_busy;
    int   hold_cycles;
    assign tx_busy = auto_mode ? model_busy : man_busy;

    int n_checks;
    int n_pass;

    logic [7:0] cap_q[$];
    logic [4:0] cap_cnt_q[$];
    int         n_launch;
    int         stab_err;
    logic       rst_window;

    uart_tx_feeder #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .i_tx_busy   (tx_busy),
        .o_start_bit (o_start_bit),
        .o_tx_data   (o_tx_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one write; returns at the negedge after the sampling edge.
    task automatic write_byte(input logic [7:0] d);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        @(negedge clk);
        i_wr_en   = 1'b0;
        $display("write 0x%02h  count=%0d full=%0d ovf=%0d", d, o_count, o_full, o_overflow);
    endtask

    task automatic wait_caps(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (cap_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(cap_q.size()), 32'(n));
    endtask

    // Launch monitor: one capture per rising o_start_bit, plus a check that
    // o_tx_data only ever changes together with a new launch.
    initial begin
        logic       start_prev;
        logic [7:0] data_prev;
        start_prev = 1'b0;
        data_prev  = '0;
        n_launch   = 0;
        stab_err   = 0;
        forever begin
            @(negedge clk);
            if (o_start_bit && !start_prev) begin
                cap_q.push_back(o_tx_data);
                cap_cnt_q.push_back(o_count);
                n_launch++;
                $display("launch #%0d data=0x%02h count=%0d", n_launch, o_tx_data, o_count);
            end else if (o_tx_data !== data_prev && !rst_window) begin
                stab_err++;
            end
            start_prev = o_start_bit;
            data_prev  = o_tx_data;
        end
    end

    // Transmitter model: busy rises 4 cycles after start, held hold_cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_mode && o_start_bit && !model_busy) begin
                repeat (4) @(negedge clk);
                model_busy = 1'b1;
                repeat (hold_cycles) @(negedge clk);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        int         base;
        int         nl;
        int         written;
        int         guard;
        logic [7:0] d;
        logic [7:0] exp_q[$];

        n_checks    = 0;
        n_pass      = 0;
        auto_mode   = 1'b0;
        man_busy    = 1'b0;
        hold_cycles = 6;
        rst_window  = 1'b1;
        i_rst       = 1'b1;
        i_wr_en     = 1'b0;
        i_wr_data   = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        rst_window = 1'b0;

        // Reset state
        check("rst_start",    32'(o_start_bit), 32'd0);
        check("rst_tx_data",  32'(o_tx_data),   32'd0);
        check("rst_full",     32'(o_full),      32'd0);
        check("rst_empty",    32'(o_empty),     32'd1);
        check("rst_count",    32'(o_count),     32'd0);
        check("rst_overflow", 32'(o_overflow),  32'd0);

        // Single byte, busy driven by hand
        write_byte(8'hA5);
        check("single_cnt_after_wr",   32'(o_count),     32'd1);
        check("single_empty_after_wr", 32'(o_empty),     32'd0);
        check("single_start_early",    32'(o_start_bit), 32'd0);
        @(negedge clk);
        check("single_start",     32'(o_start_bit), 32'd1);
        check("single_data",      32'(o_tx_data),   32'hA5);
        check("single_empty_pop", 32'(o_empty),     32'd1);
        check("single_cnt_pop",   32'(o_count),     32'd0);
        repeat (3) @(negedge clk);
        man_busy = 1'b1;
        @(negedge clk);
        check("single_start_busy1", 32'(o_start_bit), 32'd1);
        @(negedge clk);
        check("single_start_busy2", 32'(o_start_bit), 32'd1);
        @(negedge clk);
        check("single_start_drop",  32'(o_start_bit), 32'd0);
        repeat (40) @(negedge clk);
        man_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("single_launches", 32'(n_launch), 32'd1);

        // Burst 01..05 with busy held, then drain through the model
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            write_byte(8'(i + 1));
            check("burst_count", 32'(o_count), 32'(i + 1));
        end
        base        = cap_q.size();
        nl          = n_launch;
        hold_cycles = 20;
        auto_mode   = 1'b1;
        wait_caps(base + 5, 1000, "burst_timeout");
        for (int i = 0; i < 5; i++) begin
            if (base + i < cap_q.size()) begin
                check("burst_byte",      32'(cap_q[base + i]),     32'(i + 1));
                check("burst_pop_count", 32'(cap_cnt_q[base + i]), 32'(4 - i));
            end
        end
        repeat (40) @(negedge clk);
        check("burst_launches", 32'(n_launch - nl), 32'd5);

        // Fill to DEPTH, then one overflowing write
        man_busy  = 1'b1;
        auto_mode = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            write_byte(8'(8'h10 + i));
            if (i == DEPTH - 2) check("fill_not_full", 32'(o_full), 32'd0);
        end
        check("fill_full",     32'(o_full),     32'd1);
        check("fill_count",    32'(o_count),    32'd16);
        check("fill_no_ovf",   32'(o_overflow), 32'd0);
        write_byte(8'hFF);
        check("ovf_pulse",     32'(o_overflow), 32'd1);
        check("ovf_count",     32'(o_count),    32'd16);
        check("ovf_full",      32'(o_full),     32'd1);
        @(negedge clk);
        check("ovf_one_cycle", 32'(o_overflow), 32'd0);
        check("ovf_count2",    32'(o_count),    32'd16);

        // Full plus simultaneous pop: EE written exactly on the pop edge
        base     = cap_q.size();
        man_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("fullpop_pre_start", 32'(o_start_bit), 32'd0);
        write_byte(8'hEE);
        check("fullpop_start",  32'(o_start_bit), 32'd1);
        check("fullpop_count",  32'(o_count),     32'd16);
        check("fullpop_full",   32'(o_full),      32'd1);
        check("fullpop_no_ovf", 32'(o_overflow),  32'd0);
        hold_cycles = 6;
        auto_mode   = 1'b1;
        wait_caps(base + 17, 2000, "fullpop_timeout");
        for (int i = 0; i < 17; i++) begin
            if (base + i < cap_q.size()) begin
                check("fullpop_byte", 32'(cap_q[base + i]),
                      (i < 16) ? 32'(8'h10 + i) : 32'hEE);
            end
        end
        repeat (30) @(negedge clk);
        check("fullpop_total", 32'(cap_q.size()), 32'(base + 17));

        // Wrap-around: 3*DEPTH bytes, pseudo-random write/idle interleave
        base    = cap_q.size();
        written = 0;
        guard   = 0;
        while (written < 3 * DEPTH && guard < 5000) begin
            guard++;
            if (!o_full && $urandom_range(0, 2) != 0) begin
                d = 8'($urandom);
                write_byte(d);
                exp_q.push_back(d);
                written++;
            end else begin
                @(negedge clk);
            end
        end
        wait_caps(base + 3 * DEPTH, 3000, "wrap_timeout");
        for (int i = 0; i < 3 * DEPTH; i++) begin
            if (base + i < cap_q.size()) begin
                check("wrap_byte", 32'(cap_q[base + i]), 32'(exp_q[i]));
            end
        end
        repeat (30) @(negedge clk);

        // Reset while in WAIT_DONE with 3 bytes queued
        auto_mode = 1'b0;
        man_busy  = 1'b0;
        repeat (3) @(negedge clk);
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        write_byte(8'h34);
        check("rstmid_launch", 32'(o_start_bit), 32'd1);
        check("rstmid_count",  32'(o_count),     32'd3);
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_waitdone", 32'(o_start_bit), 32'd0);
        check("rstmid_data",     32'(o_tx_data),   32'h31);
        rst_window = 1'b1;
        i_rst      = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("rstmid_start", 32'(o_start_bit), 32'd0);
        check("rstmid_cnt0",  32'(o_count),     32'd0);
        check("rstmid_empty", 32'(o_empty),     32'd1);
        check("rstmid_full",  32'(o_full),      32'd0);
        check("rstmid_txd",   32'(o_tx_data),   32'd0);
        man_busy = 1'b0;
        nl       = n_launch;
        repeat (2) @(negedge clk);
        rst_window = 1'b0;
        repeat (60) @(negedge clk);
        check("rstmid_no_launch", 32'(n_launch - nl), 32'd0);
        check("rstmid_cnt_idle",  32'(o_count),       32'd0);

        check("tx_data_stable", 32'(stab_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
